// File: rtl/npc_predictor.sv
// npc_predictor: next-PC generator with a tagged, direct-mapped BTB and
// per-entry saturating direction counters.
//   clk, rst            pipeline clock, async active-high reset
//   StallF / StallE     hold PCF / block EX training and counting
//   JalD, JalTarget     JAL redirect from ID
//   JalrE, JalrTarget   JALR redirect from EX
//   BrE, BranchE, BranchTarget, PCE, PredTakenE
//                       resolved conditional branch in EX, used for training
//   PCF, PredTakenF     fetch PC register and its IF prediction
//   MispredE            EX branch direction mispredicted
//   BrCnt, MissCnt      resolved-branch and mispredict event counters
module npc_predictor #(
  parameter int                ADDR_W   = 32,
  parameter int                IDX_W    = 6,
  parameter int                CTR_W    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              StallF,
  input  logic              StallE,
  input  logic              JalD,
  input  logic [ADDR_W-1:0] JalTarget,
  input  logic              JalrE,
  input  logic [ADDR_W-1:0] JalrTarget,
  input  logic              BrE,
  input  logic              BranchE,
  input  logic [ADDR_W-1:0] BranchTarget,
  input  logic [ADDR_W-1:0] PCE,
  input  logic              PredTakenE,
  output logic [ADDR_W-1:0] PCF,
  output logic              PredTakenF,
  output logic              MispredE,
  output logic [CNT_W-1:0]  BrCnt,
  output logic [CNT_W-1:0]  MissCnt
);

  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam int DEPTH = 1 << IDX_W;
  localparam int WT_INT = 1 << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(WT_INT);      // weakly taken
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(WT_INT - 1);  // weakly not taken
  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  logic [DEPTH-1:0]             vld;
  logic [DEPTH-1:0][TAG_W-1:0]  tagMem;
  logic [DEPTH-1:0][ADDR_W-1:0] tgtMem;
  logic [DEPTH-1:0][CTR_W-1:0]  ctrMem;

  logic [IDX_W-1:0] idxF, idxE;
  logic [TAG_W-1:0] tagF, tagE;
  logic             hitF, hitE, upd;
  logic [ADDR_W-1:0] pcNext;

  // IF lookup
  assign idxF = PCF[IDX_W+1:2];
  assign tagF = PCF[ADDR_W-1:IDX_W+2];
  assign hitF = vld[idxF] & (tagMem[idxF] == tagF);
  assign PredTakenF = ~rst & hitF & ctrMem[idxF][CTR_W-1];

  // EX resolution; tagged BTB means a taken/taken pair always has the right target
  assign idxE = PCE[IDX_W+1:2];
  assign tagE = PCE[ADDR_W-1:IDX_W+2];
  assign hitE = vld[idxE] & (tagMem[idxE] == tagE);
  assign MispredE = BrE & (PredTakenE != BranchE);
  assign upd = BrE & ~StallE;

  always_comb begin
    pcNext = PCF + ADDR_W'(4);
    if (JalrE)           pcNext = JalrTarget;
    else if (MispredE)   pcNext = BranchE ? BranchTarget : PCE + ADDR_W'(4);
    else if (JalD)       pcNext = JalTarget;
    else if (PredTakenF) pcNext = tgtMem[idxF];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          PCF <= RESET_PC;
    else if (!StallF) PCF <= pcNext;
  end

  // valid bits and counters need reset; tags/targets are don't-care while invalid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld    <= '0;
      ctrMem <= {DEPTH{CTR_WNT}};
    end else if (upd) begin
      if (hitE) begin
        if (BranchE) begin
          if (ctrMem[idxE] != CTR_MAX) ctrMem[idxE] <= ctrMem[idxE] + CTR_W'(1);
        end else begin
          if (ctrMem[idxE] != '0) ctrMem[idxE] <= ctrMem[idxE] - CTR_W'(1);
        end
      end else if (BranchE) begin
        vld[idxE]    <= 1'b1;
        ctrMem[idxE] <= CTR_WT;
      end
    end
  end

  // a taken update (hit or allocate) always rewrites target; tag is
  // rewritten unchanged on a hit
  always_ff @(posedge clk) begin
    if (upd && BranchE) begin
      tagMem[idxE] <= tagE;
      tgtMem[idxE] <= BranchTarget;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      BrCnt   <= '0;
      MissCnt <= '0;
    end else if (upd) begin
      BrCnt <= BrCnt + CNT_W'(1);
      if (MispredE) MissCnt <= MissCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_npc_predictor.sv
// Directed test of npc_predictor with default parameters (IDX_W=6, CTR_W=2).
module tb_npc_predictor;
  logic        clk = 1'b0;
  logic        rst;
  logic        StallF, StallE, JalD, JalrE, BrE, BranchE, PredTakenE;
  logic [31:0] JalTarget, JalrTarget, BranchTarget, PCE;
  logic [31:0] PCF;
  logic        PredTakenF, MispredE;
  logic [31:0] BrCnt, MissCnt;

  int nChk = 0;
  int nBad = 0;

  npc_predictor dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallE(StallE),
    .JalD(JalD), .JalTarget(JalTarget), .JalrE(JalrE), .JalrTarget(JalrTarget),
    .BrE(BrE), .BranchE(BranchE), .BranchTarget(BranchTarget), .PCE(PCE),
    .PredTakenE(PredTakenE), .PCF(PCF), .PredTakenF(PredTakenF),
    .MispredE(MispredE), .BrCnt(BrCnt), .MissCnt(MissCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChk++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    StallF = 0; StallE = 0; JalD = 0; JalrE = 0; BrE = 0; BranchE = 0;
    PredTakenE = 0; JalTarget = '0; JalrTarget = '0; BranchTarget = '0; PCE = '0;
  endtask

  task automatic jumpTo(input logic [31:0] a);
    JalD = 1; JalTarget = a;
    step();
    JalD = 0;
    #1;
  endtask

  // one EX branch resolution lasting a single edge
  task automatic train(input logic [31:0] pc, input logic tk, input logic pr, input logic [31:0] tg);
    BrE = 1; PCE = pc; BranchE = tk; PredTakenE = pr; BranchTarget = tg;
    step();
    BrE = 0;
    #1;
  endtask

  initial begin
    idle();
    rst = 1;
    #12;
    chk("rst_pcf", PCF, 32'h0);
    chk("rst_pred", {31'b0, PredTakenF}, 32'h0);
    chk("rst_brcnt", BrCnt, 32'h0);
    chk("rst_misscnt", MissCnt, 32'h0);
    @(posedge clk); #1;
    rst = 0;
    #1;
    chk("seq_0", PCF, 32'h0);
    step(); chk("seq_4", PCF, 32'h4);
    step(); chk("seq_8", PCF, 32'h8);

    // cold taken branch at 0x40 -> 0x20
    BrE = 1; PCE = 32'h40; BranchE = 1; PredTakenE = 0; BranchTarget = 32'h20;
    #1;
    chk("cold_mispred", {31'b0, MispredE}, 32'h1);
    step(); BrE = 0; #1;
    chk("cold_pcf", PCF, 32'h20);
    chk("cold_miss", MissCnt, 32'h1);
    chk("cold_br", BrCnt, 32'h1);
    jumpTo(32'h40);
    chk("cold_refetch_pred", {31'b0, PredTakenF}, 32'h1);
    step(); chk("cold_pred_tgt", PCF, 32'h20);

    // hysteresis: ctr 2 -> 3 (saturate), then two not-taken
    for (int i = 0; i < 3; i++) train(32'h40, 1, 1, 32'h20);
    chk("hyst_br3", BrCnt, 32'h4);
    chk("hyst_miss3", MissCnt, 32'h1);
    train(32'h40, 0, 1, 32'h20);
    chk("hyst_nt1_pcf", PCF, 32'h44);
    jumpTo(32'h40);
    chk("hyst_nt1_pred", {31'b0, PredTakenF}, 32'h1);
    train(32'h40, 0, 1, 32'h20);
    jumpTo(32'h40);
    chk("hyst_nt2_pred", {31'b0, PredTakenF}, 32'h0);
    chk("hyst_cnt", {BrCnt[15:0], MissCnt[15:0]}, {16'd6, 16'd3});
    // same-cycle write/read of one index sees old contents
    BrE = 1; PCE = 32'h40; BranchE = 1; PredTakenE = 0; BranchTarget = 32'h20;
    #1;
    chk("wr_old_pred", {31'b0, PredTakenF}, 32'h0);
    step(); BrE = 0; #1;
    chk("wr_redirect", PCF, 32'h20);
    jumpTo(32'h40);
    chk("wr_new_pred", {31'b0, PredTakenF}, 32'h1);

    // aliasing: 0x140 shares index with 0x40
    jumpTo(32'h140);
    chk("alias_miss", {31'b0, PredTakenF}, 32'h0);
    step(); chk("alias_seq", PCF, 32'h144);
    train(32'h140, 1, 0, 32'h80);
    chk("alias_cnt", {BrCnt[15:0], MissCnt[15:0]}, {16'd8, 16'd5});
    jumpTo(32'h40);
    chk("alias_evicted", {31'b0, PredTakenF}, 32'h0);
    jumpTo(32'h140);
    chk("alias_hit", {31'b0, PredTakenF}, 32'h1);
    step(); chk("alias_tgt", PCF, 32'h80);

    // priority, with StallE so nothing trains
    StallE = 1;
    JalrE = 1; JalrTarget = 32'h300; JalD = 1; JalTarget = 32'h700;
    BrE = 1; PCE = 32'h500; BranchE = 1; PredTakenE = 0; BranchTarget = 32'h600;
    step(); chk("prio_jalr", PCF, 32'h300);
    JalrE = 0;
    step(); chk("prio_br_tk", PCF, 32'h600);
    BranchE = 0; PredTakenE = 1;
    step(); chk("prio_br_nt", PCF, 32'h504);
    BrE = 0; JalD = 0; StallE = 0;
    #1;
    chk("prio_nomis", {31'b0, MispredE}, 32'h0);
    jumpTo(32'h140);
    JalD = 1; JalTarget = 32'h700;
    #1;
    chk("prio_jal_pred", {31'b0, PredTakenF}, 32'h1);
    step(); JalD = 0;
    chk("prio_jal", PCF, 32'h700);
    chk("prio_stalle_br", BrCnt, 32'h8);

    // StallF holds PCF even against a redirect
    StallF = 1; JalD = 1; JalTarget = 32'h900;
    for (int i = 0; i < 3; i++) begin
      step(); chk("stallf_hold", PCF, 32'h700);
    end
    StallF = 0; JalD = 0;

    // StallE blocks training and counting
    StallE = 1; BrE = 1; PCE = 32'h40; BranchE = 1; PredTakenE = 0; BranchTarget = 32'h24;
    step(); step();
    chk("stalle_br", BrCnt, 32'h8);
    BrE = 0; StallE = 0;
    jumpTo(32'h40);
    chk("stalle_nobtb", {31'b0, PredTakenF}, 32'h0);
    train(32'h40, 1, 0, 32'h24);
    step();
    chk("stalle_once", {BrCnt[15:0], MissCnt[15:0]}, {16'd9, 16'd6});
    jumpTo(32'h40);
    chk("stalle_alloc", {31'b0, PredTakenF}, 32'h1);
    step(); chk("stalle_tgt", PCF, 32'h24);

    // async reset mid-run, off the clock edge
    #2; rst = 1; #1;
    chk("mrst_pcf", PCF, 32'h0);
    chk("mrst_pred", {31'b0, PredTakenF}, 32'h0);
    chk("mrst_cnt", BrCnt | MissCnt, 32'h0);
    step();
    rst = 0;
    jumpTo(32'h40);
    chk("mrst_btb_clr", {31'b0, PredTakenF}, 32'h0);

    // PC wraps modulo 2^32
    jumpTo(32'hFFFF_FFFC);
    step(); chk("pc_wrap", PCF, 32'h0);

    $display("test done: total=%0d bad=%0d", nChk, nBad);
    $finish;
  end
endmodule
